// File: rtl/ccd_row_framer_if.sv
// Bundle of the row framer's control, pixel-byte and tx FIFO write signals.
// master drives the readout side and the tx FIFO full flag; slave is the framer.
interface ccd_row_framer_if;
    logic        row_start;
    logic [15:0] row_index;
    logic        byte_valid;
    logic        byte_hi;
    logic [7:0]  ad_byte;
    logic        clear;
    logic        wfull;
    logic [7:0]  wdata;
    logic        winc;
    logic        busy;
    logic        overflow;
    logic        sync_err;
    logic        row_err;

    modport master (
        output row_start, row_index, byte_valid, byte_hi, ad_byte, clear, wfull,
        input  wdata, winc, busy, overflow, sync_err, row_err
    );

    modport slave (
        input  row_start, row_index, byte_valid, byte_hi, ad_byte, clear, wfull,
        output wdata, winc, busy, overflow, sync_err, row_err
    );
endinterface

// File: rtl/ccd_row_framer.sv
// Row framer: assembles 16-bit AD9826 pixels from MSB/LSB byte strobes into a
// small pixel FIFO and emits one packet per row (header, row index, pixels),
// padding pixels lost to overflow so every packet has exactly ROW_PIXELS pixels.
//
// Write handshake: wdata/winc are registered. A byte is launched (winc=1 for
// exactly one cycle) only from a clock edge at which wfull=0; while wfull=1
// the emitter holds its state, so no byte is lost or repeated.
module ccd_row_framer #(
    parameter logic [15:0] ROW_PIXELS     = 16'd2184,
    parameter logic [7:0]  ROW_HEADER     = 8'hC1,
    parameter logic [15:0] PAD_PIXEL      = 16'hFFFF,
    parameter int          PIX_DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    ccd_row_framer_if.slave   bus,
    output logic [2:0]        o_dbg_state
);
    localparam int DEPTH = 1 << PIX_DEPTH_LOG2;
    localparam logic [PIX_DEPTH_LOG2:0]   FIFO_FULL_CNT = {1'b1, {PIX_DEPTH_LOG2{1'b0}}};
    localparam logic [PIX_DEPTH_LOG2-1:0] PTR_ONE       = 1;
    localparam logic [PIX_DEPTH_LOG2:0]   CNT_ONE       = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_IDX_HI = 3'd2,
        S_IDX_LO = 3'd3,
        S_PIX_HI = 3'd4,
        S_PIX_LO = 3'd5
    } state_t;

    state_t r_state, w_state_nxt;

    // Capture side
    logic [15:0] r_row_index;
    logic        r_capture;
    logic        r_have_msb;
    logic [7:0]  r_msb;
    logic [15:0] r_cap_cnt;

    // Emit side
    logic [15:0] r_emit_cnt, w_emit_nxt;
    logic [7:0]  r_pix_lo, w_pix_lo_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;
    logic        r_winc, w_winc_nxt;

    // Sticky flags
    logic r_overflow, r_sync_err, r_row_err;

    // Pixel FIFO
    logic [15:0]               r_mem [DEPTH];
    logic [PIX_DEPTH_LOG2-1:0] r_wptr, r_rptr;
    logic [PIX_DEPTH_LOG2:0]   r_count;

    logic        w_busy, w_accept, w_row_err_set;
    logic        w_cap_en, w_have_msb_eff;
    logic [15:0] w_cnt_eff, w_cnt_inc, w_emit_inc;
    logic        w_push, w_pop, w_store, w_sync_set, w_ovf_set;
    logic        w_fifo_full, w_fifo_empty;
    logic [15:0] w_pixel, w_fifo_rdata;

    assign w_busy        = (r_state != S_IDLE);
    assign w_accept      = bus.row_start & ~w_busy;
    assign w_row_err_set = bus.row_start & w_busy;

    // A byte arriving with an accepted row_start belongs to the new row, so it
    // sees a fresh capture state rather than the registered one.
    assign w_cap_en       = r_capture | w_accept;
    assign w_have_msb_eff = w_accept ? 1'b0 : r_have_msb;
    assign w_cnt_eff      = w_accept ? 16'd0 : r_cap_cnt;
    assign w_cnt_inc      = w_cnt_eff + 16'd1;
    assign w_emit_inc     = r_emit_cnt + 16'd1;
    assign w_pixel        = {r_msb, bus.ad_byte};

    assign w_fifo_full  = (r_count == FIFO_FULL_CNT);
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_rdata = r_mem[r_rptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
    assign w_store   = w_push & (~w_fifo_full | w_pop);
    assign w_ovf_set = w_push & w_fifo_full & ~w_pop;

    // Byte classification: decide push and ordering error for this cycle.
    always_comb begin
        w_push     = 1'b0;
        w_sync_set = 1'b0;
        if (bus.byte_valid && w_cap_en) begin
            if (bus.byte_hi) begin
                w_sync_set = w_have_msb_eff;
            end else if (w_have_msb_eff) begin
                w_push = 1'b1;
            end else begin
                w_sync_set = 1'b1;
            end
        end
    end

    // Capture state: row latch, MSB holding register and capture counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_index <= 16'd0;
            r_capture   <= 1'b0;
            r_have_msb  <= 1'b0;
            r_msb       <= 8'd0;
            r_cap_cnt   <= 16'd0;
        end else begin
            if (w_accept) begin
                r_row_index <= bus.row_index;
                r_capture   <= 1'b1;
                r_cap_cnt   <= 16'd0;
                r_have_msb  <= 1'b0;
            end
            if (bus.byte_valid && w_cap_en) begin
                if (bus.byte_hi) begin
                    r_msb      <= bus.ad_byte;
                    r_have_msb <= 1'b1;
                end else if (w_have_msb_eff) begin
                    // Dropped pixels still count, so capture always ends on time.
                    r_have_msb <= 1'b0;
                    r_cap_cnt  <= w_cnt_inc;
                    if (w_cnt_inc == ROW_PIXELS) begin
                        r_capture <= 1'b0;
                    end
                end
            end
        end
    end

    // Pixel FIFO storage; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wptr] <= w_pixel;
        end
    end

    // Pixel FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Emitter next state and next output byte; every step waits on wfull.
    always_comb begin
        w_state_nxt  = r_state;
        w_winc_nxt   = 1'b0;
        w_wdata_nxt  = r_wdata;
        w_pop        = 1'b0;
        w_pix_lo_nxt = r_pix_lo;
        w_emit_nxt   = r_emit_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_HDR;
                    w_emit_nxt  = 16'd0;
                end
            end
            S_HDR: begin
                if (!bus.wfull) begin
                    w_winc_nxt  = 1'b1;
                    w_wdata_nxt = ROW_HEADER;
                    w_state_nxt = S_IDX_HI;
                end
            end
            S_IDX_HI: begin
                if (!bus.wfull) begin
                    w_winc_nxt  = 1'b1;
                    w_wdata_nxt = r_row_index[15:8];
                    w_state_nxt = S_IDX_LO;
                end
            end
            S_IDX_LO: begin
                if (!bus.wfull) begin
                    w_winc_nxt  = 1'b1;
                    w_wdata_nxt = r_row_index[7:0];
                    w_state_nxt = S_PIX_HI;
                end
            end
            S_PIX_HI: begin
                if (!bus.wfull) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_winc_nxt   = 1'b1;
                        w_wdata_nxt  = w_fifo_rdata[15:8];
                        w_pix_lo_nxt = w_fifo_rdata[7:0];
                        w_state_nxt  = S_PIX_LO;
                    end else if (!r_capture && (r_emit_cnt != ROW_PIXELS)) begin
                        // Capture is over and the FIFO is drained: the rest were lost.
                        w_winc_nxt   = 1'b1;
                        w_wdata_nxt  = PAD_PIXEL[15:8];
                        w_pix_lo_nxt = PAD_PIXEL[7:0];
                        w_state_nxt  = S_PIX_LO;
                    end
                end
            end
            S_PIX_LO: begin
                if (!bus.wfull) begin
                    w_winc_nxt  = 1'b1;
                    w_wdata_nxt = r_pix_lo;
                    w_emit_nxt  = w_emit_inc;
                    w_state_nxt = (w_emit_inc == ROW_PIXELS) ? S_IDLE : S_PIX_HI;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Emitter state register and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_winc     <= 1'b0;
            r_wdata    <= 8'd0;
            r_pix_lo   <= 8'd0;
            r_emit_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_winc     <= w_winc_nxt;
            r_wdata    <= w_wdata_nxt;
            r_pix_lo   <= w_pix_lo_nxt;
            r_emit_cnt <= w_emit_nxt;
        end
    end

    // Sticky error flags; a new error in the same cycle as clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_sync_err <= 1'b0;
            r_row_err  <= 1'b0;
        end else begin
            r_overflow <= (r_overflow & ~bus.clear) | w_ovf_set;
            r_sync_err <= (r_sync_err & ~bus.clear) | w_sync_set;
            r_row_err  <= (r_row_err  & ~bus.clear) | w_row_err_set;
        end
    end

    assign bus.wdata    = r_wdata;
    assign bus.winc     = r_winc;
    assign bus.busy     = w_busy;
    assign bus.overflow = r_overflow;
    assign bus.sync_err = r_sync_err;
    assign bus.row_err  = r_row_err;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_ccd_row_framer.sv
// Bench for ccd_row_framer with 4-pixel rows and a 2-entry pixel FIFO.
// Stimulus pushes expected bytes into exp_q; the monitor pops on every winc.
module tb_ccd_row_framer;
  localparam logic [15:0] ROWP = 16'd4;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  ccd_row_framer_if bus_if();

  ccd_row_framer #(
    .ROW_PIXELS(ROWP),
    .ROW_HEADER(8'hC1),
    .PAD_PIXEL(16'hFFFF),
    .PIX_DEPTH_LOG2(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] e_byte;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // monitor: every written byte must be expected, and never launched under wfull
  always @(posedge clk) begin
    #1;
    if (rst !== 1'b1 && bus_if.winc === 1'b1) begin
      check("winc_with_wfull", {15'd0, bus_if.wfull}, 16'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%h expected no write", bus_if.wdata);
      end else begin
        e_byte = exp_q.pop_front();
        check("wdata", {8'h00, bus_if.wdata}, {8'h00, e_byte});
      end
    end
  end

  // drivers
  task automatic send_byte(input logic hi, input logic [7:0] b);
    @(negedge clk);
    bus_if.byte_valid = 1'b1;
    bus_if.byte_hi    = hi;
    bus_if.ad_byte    = b;
  endtask

  task automatic idle_bytes(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.byte_valid = 1'b0;
    end
  endtask

  task automatic send_pixel(input logic [15:0] p, input int gap);
    send_byte(1'b1, p[15:8]);
    send_byte(1'b0, p[7:0]);
    idle_bytes(gap);
  endtask

  task automatic start_row(input logic [15:0] idx);
    @(negedge clk);
    bus_if.row_start = 1'b1;
    bus_if.row_index = idx;
    @(negedge clk);
    bus_if.row_start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus_if.clear = 1'b1;
    @(negedge clk);
    bus_if.clear = 1'b0;
  endtask

  task automatic push_row(input logic [15:0] idx, input logic [15:0] p0, input logic [15:0] p1,
                          input logic [15:0] p2, input logic [15:0] p3);
    exp_q.push_back(8'hC1);
    exp_q.push_back(idx[15:8]);
    exp_q.push_back(idx[7:0]);
    exp_q.push_back(p0[15:8]); exp_q.push_back(p0[7:0]);
    exp_q.push_back(p1[15:8]); exp_q.push_back(p1[7:0]);
    exp_q.push_back(p2[15:8]); exp_q.push_back(p2[7:0]);
    exp_q.push_back(p3[15:8]); exp_q.push_back(p3[7:0]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus_if.busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({name, "_busy"}, {15'd0, bus_if.busy}, 16'd0);
    check({name, "_pending"}, 16'(exp_q.size()), 16'd0);
  endtask

  task automatic check_flags(input string name, input logic ov, input logic se, input logic re);
    check({name, "_overflow"}, {15'd0, bus_if.overflow}, {15'd0, ov});
    check({name, "_sync_err"}, {15'd0, bus_if.sync_err}, {15'd0, se});
    check({name, "_row_err"},  {15'd0, bus_if.row_err},  {15'd0, re});
  endtask

  initial begin
    int n;
    rst = 1'b0;
    bus_if.row_start  = 1'b0;
    bus_if.row_index  = 16'd0;
    bus_if.byte_valid = 1'b0;
    bus_if.byte_hi    = 1'b0;
    bus_if.ad_byte    = 8'd0;
    bus_if.clear      = 1'b0;
    bus_if.wfull      = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_winc", {15'd0, bus_if.winc}, 16'd0);
    check("rst_wdata", {8'd0, bus_if.wdata}, 16'd0);
    check("rst_busy", {15'd0, bus_if.busy}, 16'd0);
    check("rst_state", {13'd0, dbg_state}, 16'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // clean row, with header latency
    push_row(16'h0102, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    @(negedge clk);
    bus_if.row_start = 1'b1;
    bus_if.row_index = 16'h0102;
    @(posedge clk);
    #1;
    check("accept_busy", {15'd0, bus_if.busy}, 16'd1);
    check("accept_winc", {15'd0, bus_if.winc}, 16'd0);
    bus_if.row_start = 1'b0;
    @(posedge clk);
    #1;
    check("hdr_winc", {15'd0, bus_if.winc}, 16'd1);
    check("hdr_wdata", {8'd0, bus_if.wdata}, 16'h00C1);
    send_pixel(16'h1234, 4);
    send_pixel(16'h5678, 4);
    send_pixel(16'h9ABC, 4);
    send_pixel(16'hDEF0, 4);
    wait_idle("clean");
    check_flags("clean", 1'b0, 1'b0, 1'b0);

    // wfull held for 5 cycles in the middle of a pixel
    push_row(16'h0304, 16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718);
    start_row(16'h0304);
    fork
      begin
        send_pixel(16'hA1B2, 5);
        send_pixel(16'hC3D4, 5);
        send_pixel(16'hE5F6, 5);
        send_pixel(16'h0718, 5);
      end
      begin
        n = 0;
        @(negedge clk);
        while (dbg_state !== 3'd5 && n < 60) begin
          @(negedge clk);
          n++;
        end
        check("stall_in_pix_lo", {13'd0, dbg_state}, 16'd5);
        bus_if.wfull = 1'b1;
        repeat (5) @(negedge clk);
        bus_if.wfull = 1'b0;
      end
    join
    wait_idle("stall");
    check_flags("stall", 1'b0, 1'b0, 1'b0);

    // overflow: 2-entry FIFO, 4 back-to-back pixels while the tx FIFO is full
    @(negedge clk);
    bus_if.wfull = 1'b1;
    push_row(16'h0506, 16'h1357, 16'h2468, 16'hFFFF, 16'hFFFF);
    start_row(16'h0506);
    send_pixel(16'h1357, 0);
    send_pixel(16'h2468, 0);
    send_pixel(16'h9BDF, 0);
    send_pixel(16'hACE0, 0);
    idle_bytes(1);
    check("ovf_early", {15'd0, bus_if.overflow}, 16'd1);
    check("ovf_stalled_busy", {15'd0, bus_if.busy}, 16'd1);
    @(negedge clk);
    bus_if.wfull = 1'b0;
    wait_idle("ovf");
    check_flags("ovf", 1'b1, 1'b0, 1'b0);
    pulse_clear();
    check_flags("ovf_clr", 1'b0, 1'b0, 1'b0);

    // bytes while idle are discarded silently
    send_pixel(16'h7777, 2);
    check("idle_bytes_busy", {15'd0, bus_if.busy}, 16'd0);
    check_flags("idle_bytes", 1'b0, 1'b0, 1'b0);

    // ordering errors: stray LSB, repeated MSB replaces the first
    push_row(16'h0708, 16'hBBCC, 16'h0001, 16'h0002, 16'h0003);
    start_row(16'h0708);
    send_byte(1'b0, 8'h11);
    send_byte(1'b1, 8'hAA);
    send_byte(1'b1, 8'hBB);
    send_byte(1'b0, 8'hCC);
    idle_bytes(3);
    send_pixel(16'h0001, 5);
    send_pixel(16'h0002, 5);
    send_pixel(16'h0003, 5);
    wait_idle("sync");
    check_flags("sync", 1'b0, 1'b1, 1'b0);
    pulse_clear();
    check_flags("sync_clr", 1'b0, 1'b0, 1'b0);

    // row_start while busy, coinciding with clear: flag still ends set
    push_row(16'h090A, 16'h0F0E, 16'h0D0C, 16'h0B0A, 16'h0908);
    start_row(16'h090A);
    fork
      begin
        send_pixel(16'h0F0E, 5);
        send_pixel(16'h0D0C, 5);
        send_pixel(16'h0B0A, 5);
        send_pixel(16'h0908, 5);
      end
      begin
        repeat (6) @(negedge clk);
        bus_if.row_start = 1'b1;
        bus_if.row_index = 16'hFFFF;
        bus_if.clear     = 1'b1;
        @(negedge clk);
        bus_if.row_start = 1'b0;
        bus_if.clear     = 1'b0;
        check("row_err_with_clear", {15'd0, bus_if.row_err}, 16'd1);
      end
    join
    wait_idle("rowerr");
    check_flags("rowerr", 1'b0, 1'b0, 1'b1);
    pulse_clear();
    check_flags("rowerr_clr", 1'b0, 1'b0, 1'b0);

    // reset after 5 bytes: winc drops at once, no padding follows
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'h0B);
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    start_row(16'h0B0C);
    send_pixel(16'h5AA5, 1);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("pre_rst_winc", {15'd0, bus_if.winc}, 16'd1);
    rst = 1'b1;
    #1;
    check("async_rst_winc", {15'd0, bus_if.winc}, 16'd0);
    check("async_rst_busy", {15'd0, bus_if.busy}, 16'd0);
    check("async_rst_state", {13'd0, dbg_state}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // new row after reset starts cleanly with the header
    push_row(16'h0D0E, 16'h1020, 16'h3040, 16'h5060, 16'h7080);
    start_row(16'h0D0E);
    send_pixel(16'h1020, 3);
    send_pixel(16'h3040, 3);
    send_pixel(16'h5060, 3);
    send_pixel(16'h7080, 3);
    wait_idle("post_rst");
    check_flags("post_rst", 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
